// File: rtl/jstk_pkg.sv
// Shared types and constants for the PmodJSTK SPI poller.
package jstk_pkg;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, GAP, DONE} jstk_state_e;

  localparam int unsigned NUM_BYTES      = 5;
  localparam logic [5:0]  LED_CMD_PREFIX = 6'b100000;
  localparam logic [9:0]  CENTRE_POS     = 10'd512;
  localparam logic [3:0]  CENTRE_DATA    = 4'd8;

endpackage

// File: rtl/spi_byte_shifter.sv
// Mode-0 SPI byte engine: CLK_DIV-cycle low then high phase per bit, MSB first.
module spi_byte_shifter #(
  parameter int unsigned CLK_DIV = 50
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       start_i,
  input  logic [7:0] tx_byte_i,
  input  logic       miso_i,
  output logic       sclk_o,
  output logic       mosi_o,
  output logic [7:0] rx_byte_o,
  output logic       done_o
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

  logic            busy_q;
  logic            sclk_q;
  logic [DivW-1:0] div_q;
  logic [2:0]      bit_q;
  logic [7:0]      tx_q;
  logic [7:0]      rx_q;
  logic            div_end;

  assign div_end   = (div_q == DivLast);
  // Asserted during the last cycle of bit 0's high phase; rx_q is complete by then.
  assign done_o    = busy_q & sclk_q & div_end & (bit_q == 3'd7);
  assign sclk_o    = sclk_q;
  assign mosi_o    = tx_q[7];
  assign rx_byte_o = rx_q;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      busy_q <= 1'b0;
      sclk_q <= 1'b0;
      div_q  <= '0;
      bit_q  <= '0;
      tx_q   <= '0;
      rx_q   <= '0;
    end else if (start_i && !busy_q) begin
      busy_q <= 1'b1;
      sclk_q <= 1'b0;
      div_q  <= '0;
      bit_q  <= '0;
      tx_q   <= tx_byte_i;
    end else if (busy_q) begin
      if (div_end) begin
        div_q <= '0;
        if (!sclk_q) begin
          sclk_q <= 1'b1;
          rx_q   <= {rx_q[6:0], miso_i};
        end else begin
          sclk_q <= 1'b0;
          bit_q  <= bit_q + 3'd1;
          // Shifting in zeros leaves Mosi low once the byte is finished.
          tx_q   <= {tx_q[6:0], 1'b0};
          if (bit_q == 3'd7) begin
            busy_q <= 1'b0;
          end
        end
      end else begin
        div_q <= div_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/joystick_reader.sv
// Periodic PmodJSTK poller: frames five SPI bytes under Ss and publishes X/Y/buttons.
module joystick_reader
  import jstk_pkg::*;
#(
  parameter int unsigned CLK_DIV       = 50,
  parameter int unsigned SS_SETUP      = 1500,
  parameter int unsigned BYTE_GAP      = 1000,
  parameter int unsigned SAMPLE_PERIOD = 1000000
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [1:0] Led_cmd,
  input  logic       Jstk_Miso,
  output logic       Jstk_Sclk,
  output logic       Jstk_Mosi,
  output logic       Jstk_Ss,
  output logic [9:0] X_pos,
  output logic [9:0] Y_pos,
  output logic [2:0] Buttons,
  output logic [3:0] Joystick_data,
  output logic       Sample_valid
);

  localparam int unsigned PerW   = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int unsigned TmrMax = (SS_SETUP > BYTE_GAP) ? SS_SETUP : BYTE_GAP;
  localparam int unsigned TmrW   = $clog2(TmrMax + 1);
  localparam int unsigned IdxW   = $clog2(NUM_BYTES);

  localparam logic [PerW-1:0] PerLast   = PerW'(SAMPLE_PERIOD - 1);
  localparam logic [TmrW-1:0] SetupLast = TmrW'(SS_SETUP - 1);
  localparam logic [TmrW-1:0] GapLast   = TmrW'(BYTE_GAP - 1);
  localparam logic [IdxW-1:0] IdxLast   = IdxW'(NUM_BYTES - 1);

  jstk_state_e     state_q;
  logic [PerW-1:0] period_q;
  logic [TmrW-1:0] timer_q;
  logic [IdxW-1:0] idx_q;
  logic [1:0]      led_q;
  logic [7:0]      x_lo_q, y_lo_q;
  logic [1:0]      x_hi_q, y_hi_q;
  logic [2:0]      btn_raw_q;
  logic            ss_q;
  logic [9:0]      x_q, y_q;
  logic [2:0]      btn_q;
  logic [3:0]      jd_q;
  logic            valid_q;

  logic            start_tx;
  logic            shift_start;
  logic [7:0]      tx_byte;
  logic [7:0]      rx_byte;
  logic            sh_done;

  always_comb begin
    start_tx    = (state_q == IDLE) && (period_q == PerLast);
    // Fires on the final wait cycle so the shifter's low phase begins as SHIFT is entered.
    shift_start = ((state_q == SETUP) && (timer_q == SetupLast)) ||
                  ((state_q == GAP) && (timer_q == GapLast));
    tx_byte     = (state_q == SETUP) ? {LED_CMD_PREFIX, led_q} : 8'h00;
  end

  // Holds at terminal count while busy so a late start is deferred, not lost.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      period_q <= '0;
    end else if (start_tx) begin
      period_q <= '0;
    end else if (period_q != PerLast) begin
      period_q <= period_q + 1'b1;
    end
  end

  spi_byte_shifter #(
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .start_i   (shift_start),
    .tx_byte_i (tx_byte),
    .miso_i    (Jstk_Miso),
    .sclk_o    (Jstk_Sclk),
    .mosi_o    (Jstk_Mosi),
    .rx_byte_o (rx_byte),
    .done_o    (sh_done)
  );

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      idx_q     <= '0;
      led_q     <= '0;
      x_lo_q    <= '0;
      x_hi_q    <= '0;
      y_lo_q    <= '0;
      y_hi_q    <= '0;
      btn_raw_q <= '0;
      ss_q      <= 1'b1;
      x_q       <= CENTRE_POS;
      y_q       <= CENTRE_POS;
      btn_q     <= '0;
      jd_q      <= CENTRE_DATA;
      valid_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_tx) begin
            state_q <= SETUP;
            ss_q    <= 1'b0;
            led_q   <= Led_cmd;
            timer_q <= '0;
            idx_q   <= '0;
          end
        end
        SETUP: begin
          if (timer_q == SetupLast) begin
            state_q <= SHIFT;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        SHIFT: begin
          if (sh_done) begin
            timer_q <= '0;
            case (idx_q)
              IdxW'(0): x_lo_q    <= rx_byte;
              IdxW'(1): x_hi_q    <= rx_byte[1:0];
              IdxW'(2): y_lo_q    <= rx_byte;
              IdxW'(3): y_hi_q    <= rx_byte[1:0];
              default:  btn_raw_q <= rx_byte[2:0];
            endcase
            state_q <= (idx_q == IdxLast) ? DONE : GAP;
          end
        end
        GAP: begin
          if (timer_q == GapLast) begin
            idx_q   <= idx_q + 1'b1;
            state_q <= SHIFT;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        DONE: begin
          ss_q    <= 1'b1;
          x_q     <= {x_hi_q, x_lo_q};
          y_q     <= {y_hi_q, y_lo_q};
          btn_q   <= btn_raw_q;
          jd_q    <= {x_hi_q, x_lo_q[7:6]};
          valid_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Jstk_Ss       = ss_q;
  assign X_pos         = x_q;
  assign Y_pos         = y_q;
  assign Buttons       = btn_q;
  assign Joystick_data = jd_q;
  assign Sample_valid  = valid_q;

endmodule

// File: tb/tb_joystick_reader.sv
// Directed bench for joystick_reader with a PmodJSTK slave model on the SPI pins.
module tb_joystick_reader;

  localparam int unsigned CLK_DIV       = 2;
  localparam int unsigned SS_SETUP      = 6;
  localparam int unsigned BYTE_GAP      = 4;
  localparam int unsigned SAMPLE_PERIOD = 400;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] led_cmd = 2'b00;
  logic       miso;
  logic       sclk, mosi, ss;
  logic [9:0] x_pos, y_pos;
  logic [2:0] buttons;
  logic [3:0] joystick_data;
  logic       sample_valid;

  always #5 clk = ~clk;

  joystick_reader #(
    .CLK_DIV       (CLK_DIV),
    .SS_SETUP      (SS_SETUP),
    .BYTE_GAP      (BYTE_GAP),
    .SAMPLE_PERIOD (SAMPLE_PERIOD)
  ) dut (
    .Clk           (clk),
    .Reset_n       (reset_n),
    .Led_cmd       (led_cmd),
    .Jstk_Miso     (miso),
    .Jstk_Sclk     (sclk),
    .Jstk_Mosi     (mosi),
    .Jstk_Ss       (ss),
    .X_pos         (x_pos),
    .Y_pos         (y_pos),
    .Buttons       (buttons),
    .Joystick_data (joystick_data),
    .Sample_valid  (sample_valid)
  );

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [2:0]  btn;
    logic [1:0]  led;
    int          exp_x;
    int          exp_y;
    int          exp_btn;
    int          exp_jd;
    logic [39:0] exp_mosi;
  } vec_t;

  vec_t vecs [5];

  int n_checks = 0;
  int n_fail   = 0;

  // Slave model and bus monitor state, all updated on the falling clock edge.
  int          cyc = 0;
  int          rises = 0;
  int          long_gaps = 0;
  int          ss_fall_cyc = 0;
  int          ss_rise_cyc = 0;
  int          first_rise_cyc = 0;
  int          last_rise_cyc = 0;
  int          byte0_fall_cyc = 0;
  int          byte1_rise_cyc = 0;
  int          valid_cycles = 0;
  logic        ss_prev = 1'b1;
  logic        sclk_prev = 1'b0;
  logic [39:0] mosi_sh = '0;
  logic [39:0] slave_bits = '0;
  logic [5:0]  miso_idx;

  assign miso_idx = 6'(39 - rises);
  assign miso     = (rises < 40) ? slave_bits[miso_idx] : 1'b0;

  always @(negedge clk) begin
    cyc       <= cyc + 1;
    ss_prev   <= ss;
    sclk_prev <= sclk;
    if (sample_valid === 1'b1) valid_cycles <= valid_cycles + 1;
    if (ss_prev === 1'b1 && ss === 1'b0) begin
      ss_fall_cyc <= cyc;
      rises       <= 0;
      long_gaps   <= 0;
      mosi_sh     <= '0;
    end
    if (ss_prev === 1'b0 && ss === 1'b1) ss_rise_cyc <= cyc;
    if (sclk_prev === 1'b0 && sclk === 1'b1) begin
      if (rises == 0) first_rise_cyc <= cyc;
      else if (cyc - last_rise_cyc != 4) long_gaps <= long_gaps + 1;
      if (rises == 8) byte1_rise_cyc <= cyc;
      last_rise_cyc <= cyc;
      rises         <= rises + 1;
      mosi_sh       <= {mosi_sh[38:0], mosi};
    end
    if (sclk_prev === 1'b1 && sclk === 1'b0 && rises == 8) byte0_fall_cyc <= cyc;
  end

  function automatic logic [39:0] mk(input logic [9:0] x, input logic [9:0] y,
                                     input logic [2:0] b);
    // Junk in the unused MISO bits must be ignored by the reader.
    return {x[7:0], 6'b101011, x[9:8], y[7:0], 6'b110101, y[9:8], 5'b11010, b};
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_ss_low(input int limit, output int n);
    n = 0;
    while (ss !== 1'b0 && n < limit) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_rises(input int target, input int limit, output int n);
    n = 0;
    while (rises < target && n < limit) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_valid(input int limit, output int n);
    n = 0;
    while (sample_valid !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ss"}, 64'(ss), 64'd1);
    check({tag, "_sclk"}, 64'(sclk), 64'd0);
    check({tag, "_mosi"}, 64'(mosi), 64'd0);
    check({tag, "_x"}, 64'(x_pos), 64'd512);
    check({tag, "_y"}, 64'(y_pos), 64'd512);
    check({tag, "_btn"}, 64'(buttons), 64'd0);
    check({tag, "_jd"}, 64'(joystick_data), 64'd8);
    check({tag, "_valid"}, 64'(sample_valid), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, expected finish before 2 ms");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int n;
    int prev_fall;
    int prev_x;
    int vc0;

    vecs[0] = '{10'h3FF, 10'h000, 3'b101, 2'b10, 1023, 0,    5, 15, 40'h82_00_00_00_00};
    vecs[1] = '{10'h17F, 10'h155, 3'b010, 2'b01, 383,  341,  2, 5,  40'h81_00_00_00_00};
    vecs[2] = '{10'h180, 10'h2AA, 3'b111, 2'b11, 384,  682,  7, 6,  40'h83_00_00_00_00};
    vecs[3] = '{10'h200, 10'h3FF, 3'b000, 2'b00, 512,  1023, 0, 8,  40'h80_00_00_00_00};
    vecs[4] = '{10'h0C5, 10'h123, 3'b011, 2'b11, 197,  291,  3, 3,  40'h83_00_00_00_00};

    reset_n    = 1'b0;
    slave_bits = mk(vecs[0].x, vecs[0].y, vecs[0].btn);
    led_cmd    = vecs[0].led;
    repeat (5) tick();
    check_reset_outputs("reset");

    reset_n = 1'b1;
    wait_ss_low(1000, n);
    check("first_start_delay", 64'(n), 64'd400);

    prev_x = 512;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        slave_bits = mk(vecs[i].x, vecs[i].y, vecs[i].btn);
        led_cmd    = vecs[i].led;
        prev_fall  = ss_fall_cyc;
        wait_ss_low(500, n);
        check($sformatf("v%0d_start_seen", i), 64'(n < 500), 64'd1);
        check($sformatf("v%0d_poll_period", i), 64'(ss_fall_cyc - prev_fall), 64'd400);
      end
      if (i == 0) begin
        wait_rises(10, 200, n);
        led_cmd = 2'b01;
      end
      wait_rises(20, 300, n);
      check($sformatf("v%0d_hold_x", i), 64'(x_pos), 64'(prev_x));
      wait_valid(300, n);
      check($sformatf("v%0d_valid_seen", i), 64'(n < 300), 64'd1);
      check($sformatf("v%0d_x", i), 64'(x_pos), 64'(vecs[i].exp_x));
      check($sformatf("v%0d_y", i), 64'(y_pos), 64'(vecs[i].exp_y));
      check($sformatf("v%0d_btn", i), 64'(buttons), 64'(vecs[i].exp_btn));
      check($sformatf("v%0d_jd", i), 64'(joystick_data), 64'(vecs[i].exp_jd));
      check($sformatf("v%0d_mosi", i), 64'(mosi_sh), 64'(vecs[i].exp_mosi));
      check($sformatf("v%0d_rises", i), 64'(rises), 64'd40);
      check($sformatf("v%0d_ss_low", i), 64'(ss_rise_cyc - ss_fall_cyc), 64'd183);
      if (i == 0) begin
        check("ss_to_first_rise", 64'(first_rise_cyc - ss_fall_cyc), 64'd8);
        check("byte_boundaries", 64'(long_gaps), 64'd4);
        check("sclk_low_byte0_1", 64'(byte1_rise_cyc - byte0_fall_cyc), 64'd6);
      end
      tick();
      check($sformatf("v%0d_valid_width", i), 64'(sample_valid), 64'd0);
      prev_x = vecs[i].exp_x;
    end
    check("valid_pulse_total", 64'(valid_cycles), 64'd5);

    // Abort during byte 2, then expect a clean restart.
    slave_bits = mk(vecs[1].x, vecs[1].y, vecs[1].btn);
    wait_ss_low(500, n);
    wait_rises(18, 200, n);
    check("abort_in_byte2", 64'(rises), 64'd18);
    reset_n = 1'b0;
    vc0     = valid_cycles;
    tick();
    check_reset_outputs("abort");
    repeat (3) tick();
    reset_n = 1'b1;
    wait_ss_low(1000, n);
    check("restart_delay", 64'(n), 64'd400);
    check("no_valid_after_abort", 64'(valid_cycles), 64'(vc0));
    wait_valid(300, n);
    check("restart_valid_seen", 64'(n < 300), 64'd1);
    check("restart_x", 64'(x_pos), 64'd383);
    check("restart_y", 64'(y_pos), 64'd341);
    check("restart_btn", 64'(buttons), 64'd2);
    check("restart_jd", 64'(joystick_data), 64'd5);
    check("restart_rises", 64'(rises), 64'd40);
    check("restart_mosi", 64'(mosi_sh), 64'h83_00_00_00_00);
    check("restart_ss_low", 64'(ss_rise_cyc - ss_fall_cyc), 64'd183);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
